// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces the
// first key found, presents its code over a valid/ready handshake, then waits for release.
module module_keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sync_rows,
  output logic [3:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held
);

  localparam int MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESENT,
    S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;

  logic [1:0] low_row;
  logic       row_high;

  // Lowest-index pressed row wins when several rows are low at once.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!sync_rows[i]) low_row = 2'(i);
    end
  end

  assign row_high = sync_rows[row_idx_q];

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    case (state_q)
      S_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (&sync_rows) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = low_row;
            state_d   = S_DEBOUNCE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (row_high) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = S_SCAN;
        end else if (cnt_q == DB_LAST) begin
          key_code_d = {row_idx_q, col_idx_q};
          cnt_d      = '0;
          state_d    = S_PRESENT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // key_valid is 1 throughout PRESENT, so key_ready alone completes the handshake.
      S_PRESENT: begin
        if (key_ready) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!row_high) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = S_SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_SCAN;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      cnt_q      <= '0;
      key_code_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
    end
  end

  assign col_drive = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = (state_q == S_PRESENT);
  assign key_held  = (state_q == S_PRESENT) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Bench for the keypad scanner: emulates a 4x4 key matrix and predicts outputs from
// scan/debounce timing arithmetic (SCAN_CYCLES = 8, DEBOUNCE_CYCLES = 4).
module tb_module_keypad_scanner;

  localparam int SC = 8;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sync_rows;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;

  logic [3:0][3:0] keys = '0;  // keys[row][col] = 1 when pressed
  int n;                        // clock edges since reset released
  int tests = 0;
  int fails = 0;
  int hs_count = 0;

  module_keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sync_rows(sync_rows), .col_drive(col_drive),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    sync_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !col_drive[c]) sync_rows[r] = 1'b0;
  end

  always @(posedge clk)
    if (!rst && key_valid && key_ready) hs_count <= hs_count + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] col_of(int c);
    logic [3:0] t;
    t = 4'b0001 << (c % 4);
    return ~t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
  endtask

  task automatic step_to(int target);
    while (n < target) step();
  endtask

  task automatic test_reset();
    keys = '0;
    key_ready = 1'b0;
    do_reset();
    tests++; if (col_drive !== 4'hE) begin fails++; $display("FAIL reset_col got %h exp e", col_drive); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code got %h exp 0", key_code); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", key_valid); end
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held got %b exp 0", key_held); end
  endtask

  task automatic test_idle_scan();
    keys = '0;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      tests++;
      if (col_drive !== col_of(n / SC) || key_valid !== 1'b0) begin
        fails++;
        $display("FAIL idle_scan n=%0d col got %h exp %h valid %b", n, col_drive, col_of(n / SC), key_valid);
      end
      step();
    end
  endtask

  task automatic test_press_r2c1();
    int hs0;
    keys = '0; keys[2][1] = 1'b1;
    do_reset();
    key_ready = 1'b1;
    hs0 = hs_count;
    step_to(SC * 2 + DB - 1);
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL r2c1_early valid got %b exp 0", key_valid); end
    step();
    tests++; if (key_valid !== 1'b1 || key_code !== 4'h9 || key_held !== 1'b1) begin
      fails++; $display("FAIL r2c1_present valid %b code %h held %b exp 1 9 1", key_valid, key_code, key_held); end
    keys = '0;
    step();
    tests++; if (key_valid !== 1'b0 || key_held !== 1'b1) begin
      fails++; $display("FAIL r2c1_handshake valid %b held %b exp 0 1", key_valid, key_held); end
    step_to(SC * 2 + DB + 4);
    tests++; if (key_held !== 1'b1 || col_drive !== 4'hD) begin
      fails++; $display("FAIL r2c1_release held %b col %h exp 1 d", key_held, col_drive); end
    step();
    tests++; if (key_held !== 1'b0 || col_drive !== 4'hB) begin
      fails++; $display("FAIL r2c1_resume held %b col %h exp 0 b", key_held, col_drive); end
    tests++; if (hs_count - hs0 !== 1) begin fails++; $display("FAIL r2c1_hs got %0d exp 1", hs_count - hs0); end
    key_ready = 1'b0;
  endtask

  task automatic test_bounce_abort();
    keys = '0; keys[0][0] = 1'b1;
    do_reset();
    key_ready = 1'b1;
    step_to(SC + 2);
    keys = '0;
    tests++; if (col_drive !== 4'hE || key_valid !== 1'b0) begin
      fails++; $display("FAIL abort_pre col %h valid %b exp e 0", col_drive, key_valid); end
    step();
    tests++; if (col_drive !== 4'hD || key_held !== 1'b0) begin
      fails++; $display("FAIL abort_col col %h held %b exp d 0", col_drive, key_held); end
    while (n < 40) begin
      step();
      tests++;
      if (key_valid !== 1'b0) begin fails++; $display("FAIL abort_valid n=%0d got 1 exp 0", n); end
      if (n == 18 || n == 19) begin
        tests++;
        if (col_drive !== ((n == 18) ? 4'hD : 4'hB)) begin
          fails++; $display("FAIL abort_scan n=%0d col got %h", n, col_drive); end
      end
    end
    key_ready = 1'b0;
  endtask

  task automatic test_two_rows();
    int hs0;
    keys = '0; keys[1][3] = 1'b1; keys[3][3] = 1'b1;
    do_reset();
    key_ready = 1'b1;
    hs0 = hs_count;
    step_to(SC * 4 + DB);
    tests++; if (key_valid !== 1'b1 || key_code !== 4'h7) begin
      fails++; $display("FAIL two_rows valid %b code %h exp 1 7", key_valid, key_code); end
    keys = '0;
    step_to(SC * 4 + DB + 5);
    tests++; if (col_drive !== 4'hE || key_held !== 1'b0) begin
      fails++; $display("FAIL two_rows_wrap col %h held %b exp e 0", col_drive, key_held); end
    step_to(60);
    tests++; if (hs_count - hs0 !== 1) begin fails++; $display("FAIL two_rows_hs got %0d exp 1", hs_count - hs0); end
    key_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    keys = '0; keys[1][0] = 1'b1;
    do_reset();
    key_ready = 1'b0;
    step_to(SC + DB);
    for (int k = 0; k < 50; k++) begin
      tests++;
      if (key_valid !== 1'b1 || key_code !== 4'h4) begin
        fails++; $display("FAIL backpressure k=%0d valid %b code %h exp 1 4", k, key_valid, key_code); end
      step();
    end
    key_ready = 1'b1;
    keys = '0;
    step();
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL bp_drop valid got 1 exp 0"); end
    key_ready = 1'b0;
  endtask

  task automatic test_release_bounce_and_reset();
    int hs0;
    keys = '0; keys[3][2] = 1'b1;
    do_reset();
    key_ready = 1'b1;
    hs0 = hs_count;
    step_to(SC * 3 + DB + 1);
    for (int i = 0; i < 10; i++) begin
      keys[3][2] = (i % 2 == 1);
      step();
      tests++;
      if (key_valid !== 1'b0 || key_held !== 1'b1) begin
        fails++; $display("FAIL bounce i=%0d valid %b held %b exp 0 1", i, key_valid, key_held); end
    end
    keys = '0;
    step(); step(); step();
    tests++; if (key_held !== 1'b1 || col_drive !== 4'hB) begin
      fails++; $display("FAIL bounce_settle held %b col %h exp 1 b", key_held, col_drive); end
    step();
    tests++; if (key_held !== 1'b0 || col_drive !== 4'h7) begin
      fails++; $display("FAIL bounce_resume held %b col %h exp 0 7", key_held, col_drive); end
    tests++; if (hs_count - hs0 !== 1) begin fails++; $display("FAIL bounce_hs got %0d exp 1", hs_count - hs0); end
    // reset while a key is being presented
    keys = '0; keys[0][1] = 1'b1;
    do_reset();
    key_ready = 1'b0;
    step_to(SC * 2 + DB);
    tests++; if (key_valid !== 1'b1 || key_code !== 4'h1) begin
      fails++; $display("FAIL pre_rst valid %b code %h exp 1 1", key_valid, key_code); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (col_drive !== 4'hE || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      fails++; $display("FAIL rst_present col %h code %h valid %b held %b exp e 0 0 0",
                        col_drive, key_code, key_valid, key_held); end
    rst = 1'b0;
    keys = '0;
  endtask

  task automatic test_random();
    int r, c, d, r2, c2, t, hs0;
    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      d = $urandom_range(0, 8);
      keys = '0; keys[r][c] = 1'b1;
      do_reset();
      key_ready = 1'b0;
      hs0 = hs_count;
      t = SC * (c + 1) + DB;
      step_to(t - 1);
      tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rand_early it=%0d valid got 1 exp 0", it); end
      step();
      tests++; if (key_valid !== 1'b1 || key_code !== 4'(r * 4 + c)) begin
        fails++; $display("FAIL rand_present it=%0d valid %b code %h exp 1 %h", it, key_valid, key_code, 4'(r * 4 + c)); end
      r2 = $urandom_range(0, 3);
      c2 = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) keys[r2][c2] = 1'b1;
      for (int k = 0; k < d; k++) begin
        step();
        tests++;
        if (key_valid !== 1'b1 || key_code !== 4'(r * 4 + c)) begin
          fails++; $display("FAIL rand_hold it=%0d valid %b code %h", it, key_valid, key_code); end
      end
      key_ready = 1'b1;
      keys = '0;
      step();
      tests++; if (key_valid !== 1'b0 || key_held !== 1'b1) begin
        fails++; $display("FAIL rand_hs it=%0d valid %b held %b exp 0 1", it, key_valid, key_held); end
      step(); step(); step();
      tests++; if (key_held !== 1'b1 || col_drive !== col_of(c)) begin
        fails++; $display("FAIL rand_rel it=%0d held %b col %h exp 1 %h", it, key_held, col_drive, col_of(c)); end
      step();
      tests++; if (key_held !== 1'b0 || col_drive !== col_of(c + 1)) begin
        fails++; $display("FAIL rand_resume it=%0d held %b col %h exp 0 %h", it, key_held, col_drive, col_of(c + 1)); end
      tests++; if (hs_count - hs0 !== 1) begin fails++; $display("FAIL rand_count it=%0d got %0d exp 1", it, hs_count - hs0); end
      key_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press_r2c1();
    test_bounce_abort();
    test_two_rows();
    test_backpressure();
    test_release_bounce_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
